controle_somador_serial: RTL

- Bit-serial add/subtract controller that time-shares one external 1-bit full-adder cell between two requesters.
- It arbitrates the requesters round-robin and latches the granted operands.
- It drives the full adder LSB-first for WIDTH cycles, carrying through an internal flop, then returns sum, carry and overflow on a valid/ready result port.
- It sits in the ULA as the low-area arithmetic path; the top level ties the fa_* ports to the team's full-adder cell.

---
 rtl/ula_pkg.sv | 13 +
 rtl/arbitro_rr2.sv | 30 +++
 rtl/controle_somador_serial.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared encodings for the ULA serial arithmetic path: controller state and requester IDs.
package ula_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/arbitro_rr2.sv
// Two-way round-robin arbiter. Grant is combinational; the pointer moves to the
// requester that lost, so it gets priority the next time both compete.
module arbitro_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else                grant = valid;
    end
  end

  // Every grant is an accept, because ready mirrors grant and grant implies valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (enable && (|valid)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/controle_somador_serial.sv
// Bit-serial add/subtract controller sharing one external full-adder cell between
// two requesters; LSB-first over WIDTH cycles, result on a valid/ready port.
module controle_somador_serial
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_id,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_r,
  input  logic             fa_cout,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high. Producers hold payload stable while valid && !ready; ready may depend
  // combinationally on valid (requester side) but valid never depends on ready.

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;

  arbitro_rr2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req1_valid, req0_valid}),
    .enable (state == IDLE),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;

  always_comb begin
    op_a   = req0_a;
    op_b   = req0_b;
    op_sub = req0_sub;
    if (grant[1]) begin
      op_a   = req1_a;
      op_b   = req1_b;
      op_sub = req1_sub;
    end
  end

  // The adder cell only sees live bits while computing; it idles at zero otherwise.
  assign fa_a      = (state == CALC) && a_reg[0];
  assign fa_b      = (state == CALC) && b_reg[0];
  assign fa_cin    = (state == CALC) && carry;
  assign res_valid = (state == DONE);
  assign res_sum   = sum_reg;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      res_cout <= 1'b0;
      res_ovf  <= 1'b0;
      res_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            a_reg  <= op_a;
            b_reg  <= op_b ^ {WIDTH{op_sub}};
            carry  <= op_sub;
            cnt    <= '0;
            res_id <= grant[1] ? REQ1 : REQ0;
            state  <= CALC;
          end
        end
        CALC: begin
          sum_reg <= {fa_r, sum_reg[WIDTH-1:1]};
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          carry   <= fa_cout;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB on this edge.
            res_cout <= fa_cout;
            res_ovf  <= carry ^ fa_cout;
            state    <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
